// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end feeding the detector's serial input X, one bit per clock.
// Define SER_PARITY_EN to append an even-parity cycle after every word.
module seq_bit_serializer #(
   parameter int DATA_W    = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit IDLE_BIT  = 1'b0,
   localparam int CW       = $clog2(DATA_W + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CW-1:0]     in_len,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              X,
   output logic              x_valid,
   output logic              frame_done,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;

   state_t            state, state_n;
   logic [DATA_W-1:0] sreg, sreg_n;
   logic [CW-1:0]     cnt, cnt_n, len_eff;
   logic              x_n, xv_n, fd_n, busy_n;
   logic              accept, last_bit;
`ifdef SER_PARITY_EN
   logic              par, par_n;
`endif

   function automatic logic head(input logic [DATA_W-1:0] v);
      return MSB_FIRST ? v[DATA_W-1] : v[0];
   endfunction

   assign last_bit = (state == SHIFT) && (cnt == CW'(1));

   // Ready opens in the final cycle of a word so the next word follows with no gap.
`ifdef SER_PARITY_EN
   assign in_ready = !rst && ((state == IDLE) || (state == PARITY));
`else
   assign in_ready = !rst && ((state == IDLE) || last_bit);
`endif

   assign accept  = in_valid && in_ready;
   assign len_eff = ((in_len == '0) || (in_len > CW'(DATA_W))) ? CW'(DATA_W) : in_len;

   // NOTE: every variable gets a default at the top of always_comb; a missing branch would infer a latch.
   always_comb begin
      state_n = state;
      sreg_n  = sreg;
      cnt_n   = cnt;
`ifdef SER_PARITY_EN
      par_n   = par;
`endif
      if (accept) begin
         state_n = SHIFT;
         // MSB-first words are left-aligned so the head is always bit DATA_W-1.
         sreg_n  = MSB_FIRST ? (in_data << (DATA_W - int'(len_eff))) : in_data;
         cnt_n   = len_eff;
`ifdef SER_PARITY_EN
         par_n   = head(sreg_n);
`endif
      end else begin
         case (state)
            SHIFT: begin
               if (last_bit) begin
`ifdef SER_PARITY_EN
                  state_n = PARITY;
`else
                  state_n = IDLE;
`endif
                  cnt_n   = '0;
               end else begin
                  sreg_n = MSB_FIRST ? (sreg << 1) : (sreg >> 1);
                  cnt_n  = cnt - CW'(1);
`ifdef SER_PARITY_EN
                  par_n  = par ^ head(sreg_n);
`endif
               end
            end
            default: state_n = IDLE;
         endcase
      end

      x_n    = IDLE_BIT;
      fd_n   = 1'b0;
      xv_n   = (state_n != IDLE);
      busy_n = (state_n != IDLE);
      if (state_n == SHIFT) begin
         x_n = head(sreg_n);
`ifndef SER_PARITY_EN
         fd_n = (cnt_n == CW'(1));
`endif
      end
`ifdef SER_PARITY_EN
      if (state_n == PARITY) begin
         x_n  = par;
         fd_n = 1'b1;
      end
`endif
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         sreg       <= '0;
         cnt        <= '0;
         X          <= IDLE_BIT;
         x_valid    <= 1'b0;
         frame_done <= 1'b0;
         busy       <= 1'b0;
`ifdef SER_PARITY_EN
         par        <= 1'b0;
`endif
      end else begin
         state      <= state_n;
         sreg       <= sreg_n;
         cnt        <= cnt_n;
         X          <= x_n;
         x_valid    <= xv_n;
         frame_done <= fd_n;
         busy       <= busy_n;
`ifdef SER_PARITY_EN
         par        <= par_n;
`endif
      end
   end

endmodule

// File: doc/seq_bit_serializer.md
Name: seq_bit_serializer

Overview:
- Parallel-to-serial front end that feeds the serial bit input X of the sequence detector stage.
- Accepts words over a valid/ready handshake and shifts them out one bit per clock, MSB first by default.
- Can stream gaplessly, back-to-back, so that a pattern spanning two words reaches the detector uninterrupted.
- Drives the idle fill bit when no word is in flight.

Parameters:
- DATA_W, 8, width of the input word in bits (2..32).
- MSB_FIRST, 1, 1 = bit DATA_W-1 sent first; 0 = bit 0 sent first.
- IDLE_BIT, 0, value driven on X when no bit is valid.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- in_data  input  DATA_W  word to serialize.
- in_len  input  $clog2(DATA_W+1)  number of bits to send from in_data (1..DATA_W); 0 means DATA_W.
- in_valid  input  1  in_data/in_len valid.
- in_ready  output  1  serializer can accept a word this cycle.
- X  output  1  serial bit to the detector.
- x_valid  output  1  X carries a payload bit this cycle.
- frame_done  output  1  one-cycle pulse coincident with the last bit of a word.
- busy  output  1  state is SHIFT.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values, registered, next cycle after rst sampled high:
  - State = IDLE, X = IDLE_BIT, x_valid = 0, frame_done = 0, busy = 0.
  - Shift register and bit counter = 0.
  - in_ready = 0 while rst is high.
- A word is accepted on the rising edge where in_valid && in_ready.
  - in_data and in_len are captured into the shift register and the counter.
  - The effective length L = (in_len == 0 || in_len > DATA_W) ? DATA_W : in_len.
- States:
  - IDLE: in_ready = 1, x_valid = 0, X = IDLE_BIT. On accept, go to SHIFT.
  - SHIFT: x_valid = 1. X = current head bit of the shift register; each bit is held exactly one cycle. The counter decrements every cycle.
    - On the last bit (count == 1): frame_done = 1 and in_ready = 1.
    - If a word is accepted in that cycle, stay in SHIFT and present the new word's first bit the next cycle, with no gap.
    - Otherwise return to IDLE.
- Latency: first bit appears on X one cycle after the accept edge. A word of L bits occupies exactly L consecutive x_valid cycles.
- When L < DATA_W:
  - MSB_FIRST=1: bits in_data[L-1:0] are sent, starting from bit L-1.
  - MSB_FIRST=0: bits 0..L-1 are sent.
  - Upper bits are ignored.
- in_ready is combinational from state and counter only. It never depends on in_valid.
- in_valid deasserted mid-word has no effect on the word already in flight.
- If rst is asserted mid-word, the word is discarded. The next cycle shows the reset values, and no frame_done is issued for the aborted word.
- All outputs except in_ready are registered.

Optional Feature:
- Macro SER_PARITY_EN.
- Defined:
  - After the last payload bit of each word, one extra cycle with x_valid = 1 carries an even-parity bit (XOR of the L sent bits).
  - frame_done moves to the parity cycle, and in_ready is asserted in the parity cycle instead of the last payload cycle.
  - A word therefore occupies L+1 cycles.
- Undefined: no parity cycle; behaviour exactly as above.

Test Plan:
- Reset then idle: rst high for 2 cycles, in_valid = 0 -> X = 0, x_valid = 0, in_ready = 0 during reset and 1 afterwards, busy = 0.
- Single word: in_data = 8'b1011_0000, in_len = 0, MSB_FIRST = 1 -> X sequence 1,0,1,1,0,0,0,0 on 8 consecutive x_valid cycles starting one cycle after accept; frame_done on the 8th bit; then IDLE with X = 0.
- Back-to-back: words 8'hB2 and 8'h5C with in_valid held high -> 16 contiguous x_valid cycles, no gap; in_ready high only in cycle 0 and in the cycle of bit 8; frame_done on bits 8 and 16.
- Short length: in_data = 8'hFF with in_len = 5 -> exactly 5 bits of 1, then X = IDLE_BIT.
- Also with MSB_FIRST = 0: in_data = 8'h0D with in_len = 4 -> X sequence 1,0,1,1.
- Reset mid-word: assert rst after bit 3 of 8'hB2 -> next cycle x_valid = 0 and no frame_done. A fresh word is then accepted normally.
- SER_PARITY_EN defined: in_data = 8'hB2 -> 8 payload bits then parity bit 0; frame_done and in_ready in the 9th cycle. With 8'hB3 -> parity bit 1.
